// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit logic/add/sub engine between two requesters,
// with a tagged, backpressured response channel and a saturating completion counter.
module alu_share_arbiter #(
  parameter int CNT_W      = 16,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [7:0]       resp_data,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       open_win, gnt_id, accept;
  logic [7:0] a_p0, b_p0, eng_p0;
  logic [2:0] op_p0;
  logic       id_p0;

  function automatic logic [7:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  alu_eval = a | b;
      3'b001:  alu_eval = ~(a & b);
      3'b010:  alu_eval = ~(a | b);
      3'b011:  alu_eval = a & b;
      3'b100:  alu_eval = a + b;
      3'b101:  alu_eval = a - b;
      default: alu_eval = 8'h00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) sat_inc = cnt;
    else      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Accept window and grant: alternate only when both requesters contend
  always_comb begin
    open_win   = !rst && ((state == IDLE) || ((state == RESP) && resp_ready));
    gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = open_win && (req0_valid || req1_valid);
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Stage p0: operands latched on acceptance, driven to the engine
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= gnt_id ? req1_a  : req0_a;
      b_p0  <= gnt_id ? req1_b  : req0_b;
      op_p0 <= gnt_id ? req1_op : req0_op;
      id_p0 <= gnt_id;
    end
  end

  assign eng_p0 = alu_eval(a_p0, b_p0, op_p0);

  // Stage p1: engine result registered into the response, held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ~FIRST_PRIO;
      resp_id    <= 1'b0;
      resp_data  <= 8'h00;
      resp_zero  <= 1'b0;
      resp_err   <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= gnt_id;
      if (state == EXEC) begin
        resp_id   <= id_p0;
        resp_data <= eng_p0;
        resp_zero <= (eng_p0 == 8'h00);
        resp_err  <= op_p0[2] & op_p0[1];
      end
      if (resp_valid && resp_ready) op_count <= sat_inc(op_count);
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: opcodes, contention, backpressure, mid-op reset
// and counter saturation (a second instance with a 2-bit counter shares the stimulus).
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, resp_ready;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp_valid, resp_id, resp_zero, resp_err, busy;
  logic [7:0]  resp_data;
  logic [15:0] op_count;
  logic        r0_2, r1_2, rv_2, rid_2, rz_2, re_2, busy_2;
  logic [7:0]  rd_2;
  logic [1:0]  cnt2;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count;
  logic [7:0]  op_tbl [7] = '{8'hDB, 8'hBD, 8'h24, 8'h42, 8'h1D, 8'h69, 8'h00};
  logic [1:0]  sat_tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  always #5 clk = ~clk;

  alu_share_arbiter #(.CNT_W(16), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy), .op_count(op_count)
  );

  alu_share_arbiter #(.CNT_W(2), .FIRST_PRIO(1'b0)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_2), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_2), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(rv_2), .resp_ready(resp_ready), .resp_id(rid_2), .resp_data(rd_2),
    .resp_zero(rz_2), .resp_err(re_2), .busy(busy_2), .op_count(cnt2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 16'd0;
  endtask

  // One isolated operation from IDLE with resp_ready high: accept, EXEC, RESP, back to IDLE
  task automatic do_op(input logic port, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] exp_d, input logic exp_err);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    if (port) chk("accept_req1", 16'(req1_ready), 16'd1);
    else      chk("accept_req0", 16'(req0_ready), 16'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_busy", 16'(busy), 16'd1);
    chk("exec_no_valid", 16'(resp_valid), 16'd0);
    step();
    chk("resp_valid", 16'(resp_valid), 16'd1);
    chk("resp_id", 16'(resp_id), 16'(port));
    chk("resp_data", 16'(resp_data), 16'(exp_d));
    chk("resp_zero", 16'(resp_zero), 16'(exp_d == 8'h00));
    chk("resp_err", 16'(resp_err), 16'(exp_err));
    exp_count = exp_count + 16'd1;
    step();
    chk("op_count", op_count, exp_count);
    chk("idle_valid", 16'(resp_valid), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'b000;
    exp_count = 16'd0;
    step();
    chk("rst_ready0", 16'(req0_ready), 16'd0);
    chk("rst_ready1", 16'(req1_ready), 16'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    chk("rst_resp_valid", 16'(resp_valid), 16'd0);
    chk("rst_resp_id", 16'(resp_id), 16'd0);
    chk("rst_resp_data", 16'(resp_data), 16'h00);
    chk("rst_resp_zero", 16'(resp_zero), 16'd0);
    chk("rst_resp_err", 16'(resp_err), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_op_count", op_count, 16'd0);

    // Single operation: 0x0F + 0xF1 wraps to zero
    do_op(1'b0, 8'h0F, 8'hF1, 3'b100, 8'h00, 1'b0);

    // Every opcode through requester 1
    for (int i = 0; i < 7; i++)
      do_op(1'b1, 8'hC3, 8'h5A, 3'(i), op_tbl[i], (i == 6));

    // Continuous contention: grants alternate starting with FIRST_PRIO
    do_reset();
    req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'b100;
    req1_a = 8'h10; req1_b = 8'h01; req1_op = 3'b100;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("cont_first_ready0", 16'(req0_ready), 16'd1);
    chk("cont_first_ready1", 16'(req1_ready), 16'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cont_exec_valid", 16'(resp_valid), 16'd0);
      step();
      chk("cont_resp_valid", 16'(resp_valid), 16'd1);
      chk("cont_resp_id", 16'(resp_id), 16'(i % 2));
      chk("cont_resp_data", 16'(resp_data), ((i % 2) == 0) ? 16'h02 : 16'h11);
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else if ((i % 2) == 0) begin
        chk("cont_ready1", 16'(req1_ready), 16'd1);
        chk("cont_noready0", 16'(req0_ready), 16'd0);
      end else begin
        chk("cont_ready0", 16'(req0_ready), 16'd1);
        chk("cont_noready1", 16'(req1_ready), 16'd0);
      end
    end
    step();
    chk("cont_idle_busy", 16'(busy), 16'd0);
    chk("cont_op_count", op_count, 16'd6);
    exp_count = 16'd6;

    // Backpressure: response held while req1 waits, req1 accepted on the resp_ready cycle
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 3'b101;
    #1;
    chk("bp_accept0", 16'(req0_ready), 16'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; req1_op = 3'b100;
    #1;
    chk("bp_exec_ready1", 16'(req1_ready), 16'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 16'(resp_valid), 16'd1);
      chk("bp_hold_data", 16'(resp_data), 16'h02);
      chk("bp_hold_id", 16'(resp_id), 16'd0);
      chk("bp_hold_ready1", 16'(req1_ready), 16'd0);
      chk("bp_hold_busy", 16'(busy), 16'd1);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_same_cycle_ready1", 16'(req1_ready), 16'd1);
    step();
    req1_valid = 1'b0;
    chk("bp_count", op_count, 16'd7);
    chk("bp_exec_valid", 16'(resp_valid), 16'd0);
    step();
    chk("bp_resp2_id", 16'(resp_id), 16'd1);
    chk("bp_resp2_data", 16'(resp_data), 16'h00);
    chk("bp_resp2_zero", 16'(resp_zero), 16'd1);
    step();
    chk("bp_count2", op_count, 16'd8);

    // Reset while in EXEC: op dropped, counter cleared, priority restored
    req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_op = 3'b000;
    #1;
    chk("mid_accept0", 16'(req0_ready), 16'd1);
    step();
    req0_valid = 1'b0;
    chk("mid_in_exec", 16'(busy), 16'd1);
    do_reset();
    chk("mid_no_valid", 16'(resp_valid), 16'd0);
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_count", op_count, 16'd0);
    step();
    chk("mid_no_valid_later", 16'(resp_valid), 16'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_prio_ready0", 16'(req0_ready), 16'd1);
    chk("mid_prio_ready1", 16'(req1_ready), 16'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("mid_resp_id", 16'(resp_id), 16'd0);
    chk("mid_resp_data", 16'(resp_data), 16'hFF);
    step();

    // Saturating 2-bit counter on the second instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, 8'(i), 8'h01, 3'b100, 8'(i + 1), 1'b0);
      chk("sat_count", 16'(cnt2), 16'(sat_tbl[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
